// File: rtl/s_countdown.sv
// Seconds down-counter: loads a 0-9 digit and steps it toward zero once per TICK_DIV clocks.
// Start/pause/resume control; one-cycle done pulse on reaching zero. All state on negedge clk.
module s_countdown #(
    parameter int FREQUENCY = 24,
    parameter int TICK_DIV  = 24000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       load,
    input  logic [3:0] preset,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] s_num,
    output logic       running,
    output logic       done_p
);

    if (TICK_DIV < 2 || TICK_DIV > 2**25 || FREQUENCY < 1) begin : g_bad_param
        $error("s_countdown: illegal TICK_DIV/FREQUENCY");
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [24:0] TOP = 25'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [3:0]  num_q, num_d;
    logic [24:0] con_q, con_d;
    logic        done_q, done_d;
    logic        run_q;
    logic        step;

    always_ff @(negedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            num_q   <= 4'd0;
            con_q   <= 25'd0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            con_q   <= con_d;
            done_q  <= done_d;
            run_q   <= (state_d == RUN);
        end
    end

    // A resume edge counts as a RUN edge, so a tick interrupted by pause is completed, not restarted.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        con_d   = con_q;
        done_d  = 1'b0;
        step    = 1'b0;
        if (load) begin
            num_d   = (preset > 4'd9) ? 4'd9 : preset;
            con_d   = 25'd0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_q == 4'd0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                            con_d   = 25'd0;
                        end
                    end
                end
                RUN: begin
                    if (pause) state_d = PAUSE;
                    else       step    = 1'b1;
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state_d = RUN;
                        step    = 1'b1;
                    end
                end
                DONE:    num_d   = 4'd0;
                default: state_d = IDLE;
            endcase
        end
        if (step) begin
            if (con_q != TOP) begin
                con_d = con_q + 25'd1;
            end else begin
                con_d = 25'd0;
                if (num_q != 4'd0) num_d = num_q - 4'd1;
                if (num_q == 4'd1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_num   = num_q;
        running = run_q;
        done_p  = done_q;
    end

endmodule

// File: tb/tb_s_countdown.sv
// Bench for s_countdown: directed timing scenarios plus random control traffic,
// all compared every cycle against a behavioural model of the countdown rules.
module tb_s_countdown;
    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       res;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] preset = 4'd0;
    logic [3:0] s_num;
    logic       running, done_p;

    int errors = 0, checks = 0, done_cnt = 0;

    // Model: mode name, current digit, RUN edges elapsed in the current second.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode = M_IDLE, m_num = 0, m_el = 0;
    bit m_done = 0;

    s_countdown #(.FREQUENCY(24), .TICK_DIV(TD)) dut (
        .clk(clk), .res(res), .load(load), .preset(preset), .start(start),
        .pause(pause), .s_num(s_num), .running(running), .done_p(done_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk or negedge res) begin
        if (!res) begin
            m_mode = M_IDLE; m_num = 0; m_el = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (load) begin
                m_num = (preset > 9) ? 9 : int'(preset);
                m_el = 0; m_mode = M_IDLE;
            end else if (m_mode == M_IDLE && start) begin
                if (m_num == 0) begin m_mode = M_DONE; m_done = 1; end
                else begin m_mode = M_RUN; m_el = 0; end
            end else if ((m_mode == M_RUN && !pause) || (m_mode == M_PAUSE && start && !pause)) begin
                m_mode = M_RUN;
                m_el++;
                if (m_el == TD) begin
                    m_el = 0;
                    m_num--;
                    if (m_num == 0) begin m_mode = M_DONE; m_done = 1; end
                end
            end else if (m_mode == M_RUN && pause) begin
                m_mode = M_PAUSE;
            end
        end
    end

    always @(posedge clk) begin
        if (res === 1'b1) begin
            chk("sb_s_num", int'(s_num), m_num);
            chk("sb_running", int'(running), int'(m_mode == M_RUN));
            chk("sb_done_p", int'(done_p), int'(m_done));
            if (done_p) done_cnt++;
        end
    end

    task automatic wait_e(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Present one strobe to exactly one falling edge.
    task automatic strobe(input logic l, input logic st, input logic pa, input logic [3:0] pr);
        load = l; start = st; pause = pa; preset = pr;
        @(posedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        int d0;
        res = 1'b1;
        #1 res = 1'b0;
        #1;
        chk("rst_s_num", int'(s_num), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_done_p", int'(done_p), 0);
        #15 res = 1'b1;
        @(posedge clk);

        // preset 3, decrements at N+10/20/30
        strobe(1, 0, 0, 4'd3);
        chk("t1_load", int'(s_num), 3);
        strobe(0, 1, 0, 4'd0);
        chk("t1_running", int'(running), 1);
        wait_e(9);  chk("t1_n9", int'(s_num), 3);
        wait_e(1);  chk("t1_n10", int'(s_num), 2);
        wait_e(10); chk("t1_n20", int'(s_num), 1);
        wait_e(9);  chk("t1_n29_done", int'(done_p), 0);
        wait_e(1);
        chk("t1_n30", int'(s_num), 0);
        chk("t1_done", int'(done_p), 1);
        chk("t1_run_fall", int'(running), 0);
        wait_e(1);  chk("t1_done_clr", int'(done_p), 0);

        // clamp 12 -> 9, nine steps of 10 cycles
        strobe(1, 0, 0, 4'd12);
        chk("t2_clamp", int'(s_num), 9);
        d0 = done_cnt;
        strobe(0, 1, 0, 4'd0);
        for (int i = 1; i <= 9; i++) begin
            wait_e(9); chk("t2_hold", int'(s_num), 10 - i);
            wait_e(1); chk("t2_step", int'(s_num), 9 - i);
        end
        wait_e(3);
        chk("t2_one_done", done_cnt - d0, 1);

        // pause at N+14, resume at M, next step M+6
        strobe(1, 0, 0, 4'd5);
        strobe(0, 1, 0, 4'd0);
        wait_e(13);
        strobe(0, 0, 1, 4'd0);
        chk("t3_paused_num", int'(s_num), 4);
        chk("t3_paused_run", int'(running), 0);
        wait_e(50);
        chk("t3_hold_num", int'(s_num), 4);
        strobe(0, 1, 0, 4'd0);
        chk("t3_resumed", int'(running), 1);
        wait_e(5); chk("t3_m5", int'(s_num), 4);
        wait_e(1); chk("t3_m6", int'(s_num), 3);

        // pause on the terminal-count edge beats the decrement
        strobe(1, 0, 0, 4'd5);
        strobe(0, 1, 0, 4'd0);
        wait_e(9);
        strobe(0, 0, 1, 4'd0);
        chk("t4_no_dec", int'(s_num), 5);
        chk("t4_paused", int'(running), 0);
        strobe(0, 1, 0, 4'd0);
        chk("t4_resume_dec", int'(s_num), 4);

        // preset 0 completes on the start edge, once
        strobe(1, 0, 0, 4'd0);
        strobe(0, 1, 0, 4'd0);
        chk("t5_done", int'(done_p), 1);
        chk("t5_num", int'(s_num), 0);
        chk("t5_run", int'(running), 0);
        wait_e(1); chk("t5_clr", int'(done_p), 0);
        for (int i = 0; i < 3; i++) begin
            strobe(0, 1, 0, 4'd0);
            chk("t5_no_redone", int'(done_p), 0);
        end

        // load aborts, then async reset aborts
        strobe(1, 0, 0, 4'd7);
        strobe(0, 1, 0, 4'd0);
        wait_e(24);
        strobe(1, 0, 0, 4'd4);
        chk("t6_load_num", int'(s_num), 4);
        chk("t6_load_run", int'(running), 0);
        chk("t6_load_done", int'(done_p), 0);
        wait_e(2);
        strobe(0, 1, 0, 4'd0);
        wait_e(24);
        #2 res = 1'b0;
        #1;
        chk("t6_rst_num", int'(s_num), 0);
        chk("t6_rst_run", int'(running), 0);
        chk("t6_rst_done", int'(done_p), 0);
        #1 res = 1'b1;
        @(posedge clk);

        // random control traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r      = $urandom_range(0, 999);
            load   = (r < 30);
            start  = ($urandom_range(0, 99) < 8);
            pause  = ($urandom_range(0, 99) < 4);
            preset = 4'($urandom_range(0, 15));
            if (r >= 995) begin
                #2 res = 1'b0;
                #1 res = 1'b1;
            end
            @(posedge clk);
        end
        load = 1'b0; start = 1'b0; pause = 1'b0;
        wait_e(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
